// File: rtl/csa_acc_pkg.sv
// csa_acc_pkg: shared types and widths for the CSA accumulation controller.
//   state_t - controller FSM state encoding
//   ACC_W   - accumulator / operand width
//   CNT_W   - width of the operand count reported with each result
package csa_acc_pkg;

  localparam int ACC_W = 90;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_RESOLVE,
    ST_OUT
  } state_t;

endpackage

// File: rtl/csa_acc_ctrl_if.sv
// csa_acc_ctrl_if: operand input stream and result output stream of the
// CSA accumulation controller.
//   in_valid/in_ready/in_data/in_last     - operand stream (master -> slave)
//   out_valid/out_ready/out_data/out_count - result stream (slave -> master)
//   out_ovf                                - only when CSA_ACC_OVF_EN is defined
// master = producer/consumer side (bench or upstream), slave = controller.
interface csa_acc_ctrl_if;
  import csa_acc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
`ifdef CSA_ACC_OVF_EN
  logic             out_ovf;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_count, out_ovf);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_count, out_ovf);
`else
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_count);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_count);
`endif

endinterface

// File: rtl/csa_acc_ctrl_csa_90.sv
// csa_90: 90-bit 3:2 carry-save adder, purely combinational.
//   x, y, z - addends
//   s       - bitwise sum
//   c       - carries shifted up one place; c[0] = 0, carry out of bit 89
//             is dropped so x + y + z == s + c (mod 2^90)
module csa_90 (
  input  logic [89:0] x,
  input  logic [89:0] y,
  input  logic [89:0] z,
  output logic [89:0] s,
  output logic [89:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[88:0] & y[88:0]) | (x[88:0] & z[88:0]) | (y[88:0] & z[88:0]), 1'b0};

endmodule

// File: rtl/csa_acc_ctrl.sv
// csa_acc_ctrl: accumulates a stream of 90-bit operands in carry/sum form
// (one per cycle through csa_90), then resolves carry/sum into binary with
// a CHUNK-bit carry-propagate adder over NCHUNK cycles and presents the
// result (mod 2^90) with the operand count.
//   clk, rst - clock, synchronous active-high reset
//   bus      - csa_acc_ctrl_if.slave (operand in, result out)
// Parameters: CHUNK (bits resolved per cycle, divides 90), MAX_OPS (2..255,
// forced termination count).
// Optional: CSA_ACC_OVF_EN adds a sticky overflow flag reported on out_ovf.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | carry/sum cleared, waiting for first operand
// ST_ACC     | accumulating operands, one per accept
// ST_RESOLVE | chunked carry propagate, chunk_q = 0..NCHUNK-1
// ST_OUT     | result presented, waiting for out_ready
module csa_acc_ctrl
  import csa_acc_pkg::*;
#(
  parameter int CHUNK   = 30,
  parameter int MAX_OPS = 16
) (
  input  logic          clk,
  input  logic          rst,
  csa_acc_ctrl_if.slave bus
);

  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHW-1:0]   LAST_CHUNK = CHW'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OPS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] c_q, s_q, res_q;
  logic [ACC_W-1:0] csa_s, csa_c;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [CHW-1:0]   chunk_q;
  logic             cin_q;
  logic             accept;
  logic             last_chunk;
  int               base;
  logic [CHUNK:0]   chunk_sum;

  csa_90 u_csa (
    .x (s_q),
    .y (c_q),
    .z (bus.in_data),
    .s (csa_s),
    .c (csa_c)
  );

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = (state_q == ST_OUT) ? res_q : '0;
  assign bus.out_count = (state_q == ST_OUT) ? cnt_q : '0;

  assign accept     = bus.in_valid && bus.in_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_chunk = (chunk_q == LAST_CHUNK);

  // One slice of the carry-propagate adder; carry chains through cin_q.
  always_comb begin
    base      = int'(chunk_q) * CHUNK;
    chunk_sum = {1'b0, s_q[base +: CHUNK]} + {1'b0, c_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, cin_q};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept) state_d = bus.in_last ? ST_RESOLVE : ST_ACC;
      ST_ACC:
        // Reaching MAX_OPS forces termination regardless of in_last.
        if (accept && (bus.in_last || cnt_inc == MAX_CNT)) state_d = ST_RESOLVE;
      ST_RESOLVE:
        if (last_chunk) state_d = ST_OUT;
      ST_OUT:
        if (bus.out_ready) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      chunk_q <= '0;
      cin_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            s_q   <= csa_s;
            c_q   <= csa_c;
            cnt_q <= cnt_inc;
          end
        end
        ST_RESOLVE: begin
          res_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cin_q                <= chunk_sum[CHUNK];
          if (!last_chunk) chunk_q <= chunk_q + 1'b1;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            c_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            chunk_q <= '0;
            cin_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q;
  logic top_carry;

  // Carry out of bit 89 that csa_90 drops on this accept.
  assign top_carry = (s_q[ACC_W-1] & c_q[ACC_W-1]) |
                     (s_q[ACC_W-1] & bus.in_data[ACC_W-1]) |
                     (c_q[ACC_W-1] & bus.in_data[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC:
          if (accept && top_carry) ovf_q <= 1'b1;
        ST_RESOLVE:
          if (last_chunk && chunk_sum[CHUNK]) ovf_q <= 1'b1;
        ST_OUT:
          if (bus.out_ready) ovf_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_ovf = (state_q == ST_OUT) ? ovf_q : 1'b0;
`endif

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// tb_csa_acc_ctrl: directed and randomized bench for csa_acc_ctrl.
// The reference result is the plain integer sum of the operands applied,
// taken mod 2^90; overflow is that sum reaching 2^90.
module tb_csa_acc_ctrl;

  localparam int CHUNK   = 30;
  localparam int MAX_OPS = 16;
  localparam int NCHUNK  = 90 / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [89:0] ops [0:255];

  csa_acc_ctrl_if bus ();

  csa_acc_ctrl #(.CHUNK(CHUNK), .MAX_OPS(MAX_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  96'(bus.in_ready),  96'd1);
    chk({tag, "_out_valid"}, 96'(bus.out_valid), 96'd0);
    chk({tag, "_out_data"},  96'(bus.out_data),  96'd0);
    chk({tag, "_out_count"}, 96'(bus.out_count), 96'd0);
`ifdef CSA_ACC_OVF_EN
    chk({tag, "_out_ovf"},   96'(bus.out_ovf),   96'd0);
`endif
  endtask

  // Called and returns at posedge+1. Applies ops[0..n-1]; in_last on the
  // final one when use_last is set.
  task automatic send_ops(input int n, input bit use_last, input bit gaps);
    bit rdy;
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ops[i];
      bus.in_last  = use_last && (i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
        w++;
      end while (!rdy && w < 20);
      if (!rdy) chk("accept_timeout", 96'(w), 96'd0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
    end
  endtask

  // Called right after the final accept (posedge+1). Checks latency, the
  // result against the model, stability under back-pressure and the
  // handshake. Returns at posedge+1.
  task automatic get_result(input int n_acc, input int hold);
    logic [98:0] total;
    int lat;
    total = '0;
    for (int i = 0; i < n_acc; i++) total += {9'd0, ops[i]};
    lat = 0;
    @(negedge clk);
    lat++;
    chk("resolve_in_ready_low", 96'(bus.in_ready), 96'd0);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 96'(lat), 96'(NCHUNK + 1));
    chk("out_data", 96'(bus.out_data), 96'(total[89:0]));
    chk("out_count", 96'(bus.out_count), 96'(n_acc));
`ifdef CSA_ACC_OVF_EN
    chk("out_ovf", 96'(bus.out_ovf), 96'(|total[98:90]));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", 96'(bus.out_valid), 96'd1);
      chk("hold_out_data", 96'(bus.out_data), 96'(total[89:0]));
      chk("hold_in_ready", 96'(bus.in_ready), 96'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", 96'(bus.in_ready), 96'd1);
    chk("post_hs_out_valid", 96'(bus.out_valid), 96'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] r;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;

    // 1 + 2 + 3, back-to-back, with 5 cycles of back-pressure
    ops[0] = 90'd1; ops[1] = 90'd2; ops[2] = 90'd3;
    send_ops(3, 1'b1, 1'b0);
    get_result(3, 5);

    // carry across a chunk boundary
    ops[0] = 90'h3FFF_FFFF; ops[1] = 90'd1;
    send_ops(2, 1'b1, 1'b0);
    get_result(2, 0);

    // wrap mod 2^90
    ops[0] = {90{1'b1}}; ops[1] = 90'd1;
    send_ops(2, 1'b1, 1'b0);
    get_result(2, 1);

    ops[0] = 90'd5; ops[1] = 90'd7;
    send_ops(2, 1'b1, 1'b0);
    get_result(2, 0);

    // forced termination at MAX_OPS without in_last
    for (int i = 0; i < MAX_OPS; i++) ops[i] = 90'd1;
    send_ops(MAX_OPS, 1'b0, 1'b0);
    get_result(MAX_OPS, 2);

    // reset in the second RESOLVE cycle
    ops[0] = 90'd100; ops[1] = 90'd200;
    send_ops(2, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    ops[0] = 90'd9;
    send_ops(1, 1'b1, 1'b0);
    get_result(1, 0);

    // randomized accumulations
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, MAX_OPS);
      for (int i = 0; i < n; i++) begin
        r = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) r[89:80] = 10'h3FF;
        ops[i] = r[89:0];
      end
      send_ops(n, 1'b1, 1'b1);
      get_result(n, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_acc_ctrl.md
# csa_acc_ctrl

Sequencing controller for the 90-bit carry-save adder in the multiprecision datapath. It accepts a stream of 90-bit operands over a valid/ready handshake and accumulates them in redundant carry/sum form, one operand per cycle, through a single `csa_90` instance. On the last operand it resolves carry/sum into a binary result with a chunked carry-propagate adder over several cycles, then presents the result downstream. It sits between partial-product generation and the Montgomery/reduction stages.

## Interface
- `CHUNK`, default 30: bits resolved per cycle; 90 must be divisible by `CHUNK`; `NCHUNK = 90/CHUNK`.
- `MAX_OPS`, default 16: maximum operands per accumulation; range 2..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: operand accepted when `in_valid && in_ready`.
- `in_data` in 90: operand.
- `in_last` in 1: final operand of the accumulation.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_data` out 90: accumulated sum mod 2^90.
- `out_count` out 8: number of operands in this result.
- `out_ovf` out 1: present only with `CSA_ACC_OVF_EN`; see Configuration.

## Operation
- FSM states: IDLE, ACC, RESOLVE, OUT.
- Registers: `c_q[89:0]`, `s_q[89:0]`, `cnt_q[7:0]`, `chunk_q`, `cin_q`, `res_q[89:0]`.
- CSA inputs are x=`s_q`, y=`c_q`, z=`in_data`. On every accept, `{c_q,s_q}` <= CSA outputs. Output `c[0]=0`. The carry out of bit 89 is discarded, so arithmetic is mod 2^90.
- IDLE: `in_ready=1`, and `c_q`/`s_q` are zero. An accept increments `cnt_q` to 1 and moves to ACC. If `in_last` is also set, go straight to RESOLVE.
- ACC: `in_ready=1`. Each accept increments `cnt_q`. Move to RESOLVE when the accept has `in_last`, or when `cnt_q` reaches `MAX_OPS` (forced termination; `in_last` ignored). Idle cycles with no `in_valid` hold state.
- RESOLVE: `in_ready=0`. Runs for `NCHUNK` cycles, chunk k = `chunk_q` from 0 upward.
  - `{cout, res_q[k*CHUNK +: CHUNK]} = s_q[...] + c_q[...] + cin_q`, then `cin_q <= cout`.
  - `cin_q` is 0 at entry.
  - After the last chunk, move to OUT.
- OUT: `out_valid=1`, `out_data=res_q`, `out_count=cnt_q`. On `out_ready`, clear `c_q`, `s_q`, `cnt_q`, `cin_q` and `chunk_q`, then go to IDLE. Outputs hold stable while `out_ready=0`.
- `in_ready` is never asserted in the same cycle as `out_valid`; there is no overlap of accumulations.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`, `out_ovf=0`. All internal registers are zero.
- Throughput: one operand per cycle in IDLE/ACC.
- Latency: final operand accepted on edge T gives RESOLVE in cycles T+1..T+`NCHUNK`, and `out_valid` high from cycle T+`NCHUNK`+1. For the default, `out_valid` is high at T+4.
- Result handshake at edge E: `in_ready` is high from cycle E+1.
- Reset mid-operation (any state) discards the partial accumulation and the pending result; the next cycle is in the reset state.
- An `in_valid` held high during RESOLVE/OUT is not consumed; the operand must remain stable until accepted.

## Configuration
- `CSA_ACC_OVF_EN` defined:
  - Adds the `out_ovf` port and a sticky `ovf_q` flag.
  - `ovf_q` is set when the discarded bit-89 carry majority(`s_q[89]`,`c_q[89]`,`in_data[89]`) is 1 on any accept, or when the final-chunk `cout` is 1.
  - `out_ovf` is valid with `out_valid` and is cleared with the result handshake.
- Undefined: no `out_ovf` port and no flag logic; wrap mod 2^90 is silent.

## Structure
- Package `csa_acc_pkg` holds:
  - the state enum type;
  - `ACC_W=90`;
  - the `out_count` width constant.
- Sub-module: exactly one instance of the existing `csa_90`.
- The chunked adder is inline in the controller. Do not make it a separate module.

## Test plan
- Operands 1, 2, 3 (last on 3) back-to-back → `out_data=6`, `out_count=3`, `out_valid` at T+4.
- Operands 2^30−1 and 1 → `out_data=2^30`. Checks the carry across a chunk boundary.
- Operands 2^90−1 and 1 → `out_data=0`. With `CSA_ACC_OVF_EN`, `out_ovf=1`; with operands 5 and 7 it is 0.
- `MAX_OPS=16`, sixteen operands of 1 with `in_last` never set → forced result `out_data=16`, `out_count=16`, and `in_ready` low after the 16th accept.
- `out_ready` held low for 5 cycles → `out_valid`/`out_data` stable, `in_ready` low. `in_ready` rises the cycle after the handshake, and the next accumulation starts from zero.
- `rst` pulsed during the second RESOLVE cycle → all outputs at reset values next cycle. A following single operand 9 with `in_last` → `out_data=9`, `out_count=1`.
